// File: rtl/lsu.sv
// Load-store unit: data memory plus memory-mapped LEDs, HEX, LCD, switches and
// buttons. Loads are combinational; stores commit on the rising clock edge.
module lsu #(
    parameter logic [31:0] DMEM_BASE   = 32'h0000_2000,
    parameter int          DMEM_WORDS  = 2048,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        st_en_i,
    input  logic [2:0]  loadsave_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic        misalign_o,
    input  logic [31:0] io_sw_i,
    input  logic [3:0]  io_btn_i,
    output logic [31:0] io_ledr_o,
    output logic [31:0] io_ledg_o,
    output logic [55:0] io_hex_o,
    output logic [31:0] io_lcd_o
);

    localparam int          AW         = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

    // I/O word addresses (byte address >> 2)
    localparam logic [13:0] A_LEDR   = 14'h1C00;
    localparam logic [13:0] A_LEDG   = 14'h1C04;
    localparam logic [13:0] A_HEX_LO = 14'h1C08;
    localparam logic [13:0] A_HEX_HI = 14'h1C09;
    localparam logic [13:0] A_LCD    = 14'h1C0C;
    localparam logic [13:0] A_SW     = 14'h1E00;
    localparam logic [13:0] A_BTN    = 14'h1E04;

    logic [31:0] dmem_q [DMEM_WORDS];
    logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
    logic [55:0] hex_q, hex_d;
    logic [SYNC_STAGES-1:0][31:0] sw_sync_q;
    logic [SYNC_STAGES-1:0][3:0]  btn_sync_q;

    logic        hi_ok, in_dmem, mapped;
    logic [31:0] dmem_off;
    logic [AW-1:0] dmem_idx;
    logic [13:0] io_word;
    logic sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_lcd, sel_sw, sel_btn;
    logic is_byte, is_half, is_word, ld_legal, st_legal, st_ok;
    logic [3:0]  be;
    logic [31:0] st_wdata, rd_word, rd_shift;
    logic [15:0] half_sel;
    logic we_dmem, we_ledr, we_ledg, we_hex_lo, we_hex_hi, we_lcd;

    // Replace the enabled byte lanes of a register word with new data.
    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  lanes);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = lanes[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

    // Address decode; every region lives in the low 64 KiB.
    always_comb begin
        hi_ok      = (addr_i[31:16] == 16'h0);
        dmem_off   = addr_i - DMEM_BASE;
        in_dmem    = hi_ok && (addr_i >= DMEM_BASE) && (dmem_off < DMEM_BYTES);
        dmem_idx   = dmem_off[AW+1:2];
        io_word    = addr_i[15:2];
        sel_ledr   = hi_ok && (io_word == A_LEDR);
        sel_ledg   = hi_ok && (io_word == A_LEDG);
        sel_hex_lo = hi_ok && (io_word == A_HEX_LO);
        sel_hex_hi = hi_ok && (io_word == A_HEX_HI);
        sel_lcd    = hi_ok && (io_word == A_LCD);
        sel_sw     = hi_ok && (io_word == A_SW);
        sel_btn    = hi_ok && (io_word == A_BTN);
        mapped     = in_dmem | sel_ledr | sel_ledg | sel_hex_lo | sel_hex_hi
                   | sel_lcd | sel_sw | sel_btn;
    end

    // Access size, legality, alignment, lane enables and replicated store data.
    always_comb begin
        is_byte    = (loadsave_op_i[1:0] == 2'b00);
        is_half    = (loadsave_op_i[1:0] == 2'b01);
        is_word    = (loadsave_op_i == 3'b010);
        ld_legal   = is_byte | is_half | is_word;
        st_legal   = !loadsave_op_i[2] && (loadsave_op_i[1:0] != 2'b11);
        misalign_o = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
        be         = 4'b0000;
        st_wdata   = st_data_i;
        if (is_byte) begin
            be       = 4'b0001 << addr_i[1:0];
            st_wdata = {4{st_data_i[7:0]}};
        end else if (is_half) begin
            be       = addr_i[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data_i[15:0]}};
        end else if (is_word) begin
            be       = 4'b1111;
        end
        st_ok      = st_en_i && st_legal && !misalign_o;
        we_dmem    = st_ok && in_dmem && rst_ni;
        we_ledr    = st_ok && sel_ledr;
        we_ledg    = st_ok && sel_ledg;
        we_hex_lo  = st_ok && sel_hex_lo;
        we_hex_hi  = st_ok && sel_hex_hi;
        we_lcd     = st_ok && sel_lcd;
    end

    // Next-state for the writable I/O registers; HEX keeps 7 bits per digit.
    always_comb begin
        ledr_d = we_ledr ? merge(ledr_q, st_wdata, be) : ledr_q;
        ledg_d = we_ledg ? merge(ledg_q, st_wdata, be) : ledg_q;
        lcd_d  = we_lcd  ? merge(lcd_q,  st_wdata, be) : lcd_q;
        hex_d  = hex_q;
        for (int d = 0; d < 8; d++) begin
            if (((d < 4) ? we_hex_lo : we_hex_hi) && be[d % 4])
                hex_d[7*d +: 7] = st_wdata[8*(d % 4) +: 7];
        end
    end

    // I/O registers and input synchronisers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ledr_q     <= '0;
            ledg_q     <= '0;
            lcd_q      <= '0;
            hex_q      <= '0;
            sw_sync_q  <= '0;
            btn_sync_q <= '0;
        end else begin
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            lcd_q      <= lcd_d;
            hex_q      <= hex_d;
            sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], io_sw_i};
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], io_btn_i};
        end
    end

    // Data memory: byte-lane synchronous write, never reset.
    always_ff @(posedge clk_i) begin
        if (we_dmem) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) dmem_q[dmem_idx][8*b +: 8] <= st_wdata[8*b +: 8];
        end
    end

    // Read-word mux; DMEM read is asynchronous so loads see pre-edge contents.
    always_comb begin
        rd_word = '0;
        if (in_dmem)         rd_word = dmem_q[dmem_idx];
        else if (sel_ledr)   rd_word = ledr_q;
        else if (sel_ledg)   rd_word = ledg_q;
        else if (sel_hex_lo) rd_word = {1'b0, hex_q[27:21], 1'b0, hex_q[20:14],
                                        1'b0, hex_q[13:7],  1'b0, hex_q[6:0]};
        else if (sel_hex_hi) rd_word = {1'b0, hex_q[55:49], 1'b0, hex_q[48:42],
                                        1'b0, hex_q[41:35], 1'b0, hex_q[34:28]};
        else if (sel_lcd)    rd_word = lcd_q;
        else if (sel_sw)     rd_word = sw_sync_q[SYNC_STAGES-1];
        else if (sel_btn)    rd_word = {28'b0, btn_sync_q[SYNC_STAGES-1]};
    end

    // Lane select and sign/zero extension of load data.
    always_comb begin
        rd_shift  = rd_word >> {addr_i[1:0], 3'b000};
        half_sel  = addr_i[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data_o = '0;
        if (ld_legal && !misalign_o && mapped) begin
            if (is_byte)
                ld_data_o = loadsave_op_i[2] ? {24'b0, rd_shift[7:0]}
                                             : {{24{rd_shift[7]}}, rd_shift[7:0]};
            else if (is_half)
                ld_data_o = loadsave_op_i[2] ? {16'b0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            else
                ld_data_o = rd_word;
        end
    end

    assign io_ledr_o = ledr_q;
    assign io_ledg_o = ledg_q;
    assign io_hex_o  = hex_q;
    assign io_lcd_o  = lcd_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: load results go through a scoreboard queue,
// register outputs are compared directly against bench-held expectations.
module tb_lsu;

    logic        clk, rst_n, st_en, misalign;
    logic [2:0]  op;
    logic [31:0] addr, st_data, ld_data, sw, ledr, ledg, lcd;
    logic [3:0]  btn;
    logic [55:0] hex, hex_exp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100,
                           LHU = 3'b101, ILL = 3'b011;

    lsu dut (
        .clk_i(clk), .rst_ni(rst_n), .st_en_i(st_en), .loadsave_op_i(op),
        .addr_i(addr), .st_data_i(st_data), .ld_data_o(ld_data),
        .misalign_o(misalign), .io_sw_i(sw), .io_btn_i(btn),
        .io_ledr_o(ledr), .io_ledg_o(ledg), .io_hex_o(hex), .io_lcd_o(lcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one store and let it commit on the next rising edge.
    task automatic store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        op = o; addr = a; st_data = d; st_en = 1'b1;
        @(posedge clk); #1;
        st_en = 1'b0;
        $display("store op=%b addr=%h data=%h", o, a, d);
    endtask

    // Drive a load and queue the value it must return.
    task automatic drive_load(input string tag, input logic [2:0] o,
                              input logic [31:0] a, input logic [31:0] exp);
        op = o; addr = a;
        sb_q.push_back('{tag, exp});
    endtask

    // Pop the oldest expectation and compare against the combinational output.
    task automatic check_load();
        sb_t it;
        #2;
        it = sb_q.pop_front();
        $display("load %s addr=%h data=%h", it.tag, addr, ld_data);
        check(it.tag, ld_data, it.exp);
    endtask

    task automatic load(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] exp);
        st_en = 1'b0;
        drive_load(tag, o, a, exp);
        check_load();
    endtask

    initial begin
        clk = 0; rst_n = 0; sw = '0; btn = '0; hex_exp = '0;
        st_en = 1'b1; op = LW; addr = 32'h7000; st_data = 32'hDEADBEEF;

        // Stores held off while in reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_ledr", ledr, 32'h0);
        check("rst_ledg", ledg, 32'h0);
        check("rst_hex",  hex,  56'h0);
        check("rst_lcd",  lcd,  32'h0);
        st_en = 1'b0;
        rst_n = 1'b1;

        store(LW, 32'h7000, 32'hDEADBEEF);
        check("ledr_st", ledr, 32'hDEADBEEF);
        load("lw_ledr", LW, 32'h7000, 32'hDEADBEEF);

        // Byte/half lanes and extension
        store(LW, 32'h2000, 32'h11223344);
        store(LB, 32'h2001, 32'h000000AB);
        load("sb_word", LW,  32'h2000, 32'h1122AB44);
        load("lb",      LB,  32'h2001, 32'hFFFFFFAB);
        load("lbu",     LBU, 32'h2001, 32'h000000AB);
        load("lh",      LH,  32'h2002, 32'h00001122);
        load("lb3",     LB,  32'h2003, 32'h00000011);
        store(LH, 32'h2002, 32'h00008000);
        load("lh_neg",  LH,  32'h2002, 32'hFFFF8000);
        load("lhu",     LHU, 32'h2002, 32'h00008000);
        load("lhu_lo",  LHU, 32'h2000, 32'h0000AB44);

        // Misaligned and unmapped
        op = LW; addr = 32'h2002; st_data = 32'h12345678; st_en = 1'b1;
        #2 check("misal_w", misalign, 1'b1);
        @(posedge clk); #1; st_en = 1'b0;
        load("misal_nochg", LW, 32'h2000, 32'h8000AB44);
        load("misal_ld",    LW, 32'h2002, 32'h0);
        op = LH; addr = 32'h2001;
        #1 check("misal_h", misalign, 1'b1);
        op = LH; addr = 32'h2002;
        #1 check("align_h", misalign, 1'b0);
        store(LW, 32'h5000, 32'hCAFEF00D);
        store(LW, 32'h1_7000, 32'hCAFEF00D);
        check("unmap_ledr", ledr, 32'hDEADBEEF);
        check("unmap_ledg", ledg, 32'h0);
        load("unmap_dmem", LW, 32'h2000, 32'h8000AB44);
        load("unmap_ld",   LW, 32'h1_7000, 32'h0);
        load("unmap_5000", LW, 32'h5000, 32'h0);

        // Other I/O registers
        store(LW, 32'h7010, 32'h0F0F0F0F);
        check("ledg_st", ledg, 32'h0F0F0F0F);
        store(LW, 32'h7030, 32'h12345678);
        check("lcd_st", lcd, 32'h12345678);
        load("lw_lcd", LW, 32'h7030, 32'h12345678);

        // HEX lanes
        store(LW, 32'h7020, 32'h01020304);
        hex_exp[6:0] = 7'h04; hex_exp[13:7] = 7'h03; hex_exp[20:14] = 7'h02; hex_exp[27:21] = 7'h01;
        check("hex_lo", hex, hex_exp);
        load("lw_hex_lo", LW, 32'h7020, 32'h01020304);
        store(LB, 32'h7026, 32'h000000FF);
        hex_exp[48:42] = 7'h7F;
        check("hex_d6", hex, hex_exp);
        store(ILL, 32'h7024, 32'h0);
        check("ill_hex", hex, hex_exp);
        store(ILL, 32'h2000, 32'h0);
        load("ill_dmem", LW, 32'h2000, 32'h8000AB44);
        load("ill_ld",   ILL, 32'h2000, 32'h0);

        // Synchroniser latency: change just after edge k
        sw = 32'h0000A5A5;
        load("sw_k", LW, 32'h7800, 32'h0);
        @(posedge clk); #1;
        load("sw_k1", LW, 32'h7800, 32'h0);
        @(posedge clk); #1;
        load("sw_k2", LW, 32'h7800, 32'h0000A5A5);
        store(LW, 32'h7800, 32'hFFFFFFFF);
        load("sw_ro", LW, 32'h7800, 32'h0000A5A5);
        btn = 4'b1010;
        repeat (2) @(posedge clk);
        #1;
        load("btn", LW, 32'h7810, 32'h0000000A);

        // Read-during-write
        store(LW, 32'h2010, 32'h1);
        op = LW; addr = 32'h2010; st_data = 32'h2; st_en = 1'b1;
        drive_load("rdw_old", LW, 32'h2010, 32'h1);
        check_load();
        @(posedge clk); #1; st_en = 1'b0;
        load("rdw_new", LW, 32'h2010, 32'h2);

        // Mid-operation asynchronous reset
        op = LW; addr = 32'h7000; st_data = 32'h55; st_en = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("async_ledr", ledr, 32'h0);
        check("async_hex", hex, 56'h0);
        st_en = 1'b0;
        load("async_sw", LW, 32'h7800, 32'h0);
        op = LW; addr = 32'h2010; st_data = 32'h3; st_en = 1'b1;
        @(posedge clk); #1;
        st_en = 1'b0; rst_n = 1'b1;
        check("rst_lost", ledr, 32'h0);
        load("rst_dmem", LW, 32'h2010, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
